rvv_mwmr_fifo: RTL

//  Parametrised multi-write/multi-read FIFO; replaces fixed 1W1R/2W2R/4W2R variants in the RVV datapath.

---
 rtl/rvv_mwmr_fifo_pkg.sv | 13 +
 rtl/rvv_mwmr_fifo_if.sv | 34 +++
 rtl/rvv_mwmr_fifo_push_compact.sv | 17 +
 rtl/rvv_mwmr_fifo.sv | 101 ++++++++++
 4 files changed

// File: rtl/rvv_mwmr_fifo_pkg.sv
// rvv_mwmr_fifo_pkg: width helpers and modular pointer arithmetic shared by the FIFO files
package rvv_mwmr_fifo_pkg;
  function automatic int ptr_w(int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction
  function automatic int cnt_w(int depth);
    return $clog2(depth + 1);
  endfunction
  // inc never exceeds depth, so one conditional subtract wraps any DEPTH
  function automatic int ptr_add(int ptr, int inc, int depth);
    return (ptr + inc >= depth) ? ptr + inc - depth : ptr + inc;
  endfunction
endpackage

// File: rtl/rvv_mwmr_fifo_if.sv
// rvv_mwmr_fifo_if: push/pop bus and status of the multi-write/multi-read FIFO
interface rvv_mwmr_fifo_if
  import rvv_mwmr_fifo_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 8,
  parameter int NWR    = 2,
  parameter int NRD    = 2
);
  logic                    i_flush;
  logic                    i_err_clr;
  logic [NWR-1:0]          i_push;
  logic [NWR*DWIDTH-1:0]   i_push_data;
  logic [NRD-1:0]          i_pop;
  logic [NRD*DWIDTH-1:0]   o_pop_data;
  logic [NRD-1:0]          o_pop_valid;
  logic [cnt_w(DEPTH)-1:0] o_count;
  logic                    o_empty;
  logic                    o_full;
  logic                    o_half_full;
  logic [NWR-1:0]          o_almost_full;
  logic                    o_overflow;
  logic                    o_underflow;
  modport master (
    output i_flush, i_err_clr, i_push, i_push_data, i_pop,
    input  o_pop_data, o_pop_valid, o_count, o_empty, o_full, o_half_full,
           o_almost_full, o_overflow, o_underflow
  );
  modport slave (
    input  i_flush, i_err_clr, i_push, i_push_data, i_pop,
    output o_pop_data, o_pop_valid, o_count, o_empty, o_full, o_half_full,
           o_almost_full, o_overflow, o_underflow
  );
endinterface

// File: rtl/rvv_mwmr_fifo_push_compact.sv
// rvv_mwmr_fifo_push_compact: prefix popcount giving each push port its slot offset and the total
module rvv_mwmr_fifo_push_compact #(
  parameter int NWR = 2,
  parameter int OW  = $clog2(NWR + 1)
) (
  input  logic [NWR-1:0]         i_req,
  output logic [NWR-1:0][OW-1:0] o_off,
  output logic [OW-1:0]          o_total
);
  always_comb begin
    o_total = '0;
    for (int i = 0; i < NWR; i++) begin
      o_off[i] = o_total;
      o_total  = o_total + OW'(i_req[i]);
    end
  end
endmodule

// File: rtl/rvv_mwmr_fifo.sv
// rvv_mwmr_fifo: parametrised NWR-push / NRD-pop FIFO with first-word fall-through and sticky errors
module rvv_mwmr_fifo
  import rvv_mwmr_fifo_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 8,
  parameter int NWR    = 2,
  parameter int NRD    = 2
) (
  input logic           clk,
  input logic           rst_n,
  rvv_mwmr_fifo_if.slave io_bus
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int OW = $clog2(NWR + 1);
  if (DEPTH < NWR || NRD > DEPTH || NWR < 1 || NRD < 1) begin : g_bad_cfg
    $error("rvv_mwmr_fifo: DEPTH must be >= NWR and >= NRD");
  end
  logic [DWIDTH-1:0]     r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;
  logic                  r_unf;
  logic [NWR-1:0][OW-1:0] w_off;
  logic [OW-1:0]         w_total;
  logic [NWR-1:0]        w_we;
  logic [NWR-1:0][PW-1:0] w_slot;
  int                    w_free;
  int                    w_acc_push;
  int                    w_npop;
  int                    w_acc_pop;
  logic                  w_run;
  logic                  w_gap;
  logic                  w_ovf_set;
  logic                  w_unf_set;
  rvv_mwmr_fifo_push_compact #(.NWR(NWR), .OW(OW)) u_compact (
    .i_req   (io_bus.i_push),
    .o_off   (w_off),
    .o_total (w_total)
  );
  // pushes and pops are both judged against the cycle-start count
  always_comb begin
    w_free     = DEPTH - int'(r_count);
    w_ovf_set  = int'(w_total) > w_free;
    w_acc_push = w_ovf_set ? w_free : int'(w_total);
    for (int i = 0; i < NWR; i++) begin
      w_we[i]   = io_bus.i_push[i] && (int'(w_off[i]) < w_free);
      w_slot[i] = PW'(ptr_add(int'(r_wr_ptr), int'(w_off[i]), DEPTH));
    end
    w_run  = 1'b1;
    w_gap  = 1'b0;
    w_npop = 0;
    for (int j = 0; j < NRD; j++) begin
      w_gap  = w_gap | (io_bus.i_pop[j] & ~w_run);
      w_npop = w_npop + int'(io_bus.i_pop[j] & w_run);
      w_run  = w_run & io_bus.i_pop[j];
    end
    w_unf_set = w_gap || (w_npop > int'(r_count));
    w_acc_pop = (w_npop > int'(r_count)) ? int'(r_count) : w_npop;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      r_ovf <= (r_ovf & ~io_bus.i_err_clr) | (w_ovf_set & ~io_bus.i_flush);
      r_unf <= (r_unf & ~io_bus.i_err_clr) | (w_unf_set & ~io_bus.i_flush);
      if (io_bus.i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_wr_ptr <= PW'(ptr_add(int'(r_wr_ptr), w_acc_push, DEPTH));
        r_rd_ptr <= PW'(ptr_add(int'(r_rd_ptr), w_acc_pop, DEPTH));
        r_count  <= CW'(int'(r_count) + w_acc_push - w_acc_pop);
        for (int i = 0; i < NWR; i++)
          if (w_we[i]) r_mem[w_slot[i]] <= io_bus.i_push_data[i*DWIDTH +: DWIDTH];
      end
    end
  end
  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      io_bus.o_pop_data[j*DWIDTH +: DWIDTH] = r_mem[PW'(ptr_add(int'(r_rd_ptr), j, DEPTH))];
      io_bus.o_pop_valid[j] = int'(r_count) > j;
    end
    for (int k = 0; k < NWR; k++)
      io_bus.o_almost_full[k] = (DEPTH - int'(r_count)) <= k + 1;
    io_bus.o_count     = r_count;
    io_bus.o_empty     = r_count == '0;
    io_bus.o_full      = int'(r_count) == DEPTH;
    io_bus.o_half_full = int'(r_count) >= DEPTH / 2;
    io_bus.o_overflow  = r_ovf;
    io_bus.o_underflow = r_unf;
  end
endmodule
